// File: rtl/bus_arbiter.sv
// Arbiter that shares one external memory bus between the fetch (IF) and data (MEM) ports.
// MEM wins by default; a starvation counter forces IF through, flush discards fetches, and stuck cycles time out.
module bus_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int TIMEOUT      = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ack,
  input  logic            mem_req,
  input  logic            mem_we,
  input  logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_wdata,
  input  logic [DW/8-1:0] mem_wstrb,
  output logic [DW-1:0]   mem_rdata,
  output logic            mem_ack,
  output logic            bus_req,
  output logic            bus_we,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  output logic [DW/8-1:0] bus_wstrb,
  input  logic [DW-1:0]   bus_rdata,
  input  logic            bus_ack,
  output logic            bus_err
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] starve_cnt;
  logic          drop;

  logic busy, timeout_hit, finish, if_elig, starved, grant_if, grant_mem;

  assign busy        = (state != IDLE);
  // A real bus_ack always beats a coincident timeout.
  assign timeout_hit = busy && !bus_ack && (tcnt == TW'(TIMEOUT - 1));
  assign finish      = busy && (bus_ack || timeout_hit);
  assign if_elig     = if_req && !flush;
  assign starved     = (starve_cnt == SW'(STARVE_LIMIT));
  assign grant_if    = (state == IDLE) && if_elig && (starved || !mem_req);
  assign grant_mem   = (state == IDLE) && mem_req && !(starved && if_elig);

  assign bus_err   = timeout_hit;
  assign if_ack    = (state == IF_BUSY) && finish && !drop;
  assign mem_ack   = (state == MEM_BUSY) && finish;
  assign if_rdata  = ((state == IF_BUSY) && bus_ack) ? bus_rdata : '0;
  assign mem_rdata = ((state == MEM_BUSY) && bus_ack) ? bus_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      starve_cnt <= '0;
      drop       <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wstrb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= '0;
          drop <= 1'b0;
          if (grant_if) begin
            state      <= IF_BUSY;
            bus_req    <= 1'b1;
            bus_we     <= 1'b0;
            bus_addr   <= if_addr;
            bus_wdata  <= '0;
            bus_wstrb  <= '0;
            starve_cnt <= '0;
          end else if (grant_mem) begin
            state     <= MEM_BUSY;
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
            bus_wstrb <= mem_wstrb;
            if (!if_req)
              starve_cnt <= '0;
            else if (!starved)
              starve_cnt <= starve_cnt + SW'(1);
          end else if (!if_req) begin
            starve_cnt <= '0;
          end
        end
        default: begin
          if (finish) begin
            state     <= IDLE;
            tcnt      <= '0;
            drop      <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
            // A flushed fetch still runs to completion on the bus, but its result is discarded.
            if (state == IF_BUSY && flush)
              drop <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter: random IF/MEM requesters, flushes and a slave with random (or no) ack latency,
// checked every cycle against a transaction-level reference model.
module tb_bus_arbiter;
  localparam int AW = 32, DW = 32, TIMEOUT = 16, STARVE_LIMIT = 4, NCYC = 3000;

  logic          clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic          if_req = 1'b0, if_ack;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          mem_req = 1'b0, mem_we = 1'b0, mem_ack;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0, mem_rdata;
  logic [3:0]    mem_wstrb = '0;
  logic          bus_req, bus_we, bus_err;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [3:0]    bus_wstrb;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_ack = 1'b0;

  bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus (0 none, 1 fetch, 2 data), what the granted request looked like,
  // how long it has been outstanding, whether it was flushed, and how many data grants IF has sat through.
  int            owner = 0, age = 0, streak = 0, ntxn = 0;
  bit            dropped = 0;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata;
  logic          t_we;
  logic [3:0]    t_wstrb;

  // Stimulus-side bookkeeping
  bit seen_if_ack = 0, seen_mem_ack = 0, last_flush = 0, sl_active = 0;
  int sl_cnt = 0, sl_lat = 0;

  task automatic model_reset();
    owner = 0; age = 0; streak = 0; dropped = 0;
    seen_if_ack = 0; seen_mem_ack = 0; last_flush = 0; sl_active = 0;
  endtask

  initial begin
    bit ok_done, abort, elig;
    int p_flush, p_hang;

    @(negedge clk);
    #1;
    check_val("rst_bus_req", bus_req, 0);
    check_val("rst_bus_addr", bus_addr, 0);
    check_val("rst_bus_we", bus_we, 0);
    check_val("rst_if_ack", if_ack, 0);
    check_val("rst_mem_ack", mem_ack, 0);
    check_val("rst_bus_err", bus_err, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      p_flush = (cyc >= 1000 && cyc < 2000) ? 20 : 3;
      p_hang  = (cyc >= 2000) ? 30 : 3;

      if (if_req && (seen_if_ack || last_flush)) begin
        if ($urandom_range(1, 0) == 1) if_addr = $urandom & 32'hFFFF_FFFC;
        else if_req = 1'b0;
      end else if (!if_req && $urandom_range(99, 0) < 60) begin
        if_req  = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if ((mem_req && seen_mem_ack) || (!mem_req && $urandom_range(99, 0) < 80)) begin
        if (mem_req && $urandom_range(99, 0) < 20) mem_req = 1'b0;
        else begin
          mem_req   = 1'b1;
          mem_we    = 1'($urandom);
          mem_addr  = $urandom;
          mem_wdata = $urandom;
          mem_wstrb = 4'($urandom);
        end
      end
      flush     = ($urandom_range(99, 0) < p_flush);
      bus_rdata = $urandom;
      if (bus_req && !sl_active) begin
        sl_active = 1;
        sl_cnt    = 0;
        sl_lat    = ($urandom_range(99, 0) < p_hang) ? 1000 : int'($urandom_range(4, 0));
      end
      bus_ack = sl_active ? (sl_cnt == sl_lat) : ($urandom_range(99, 0) < 10);

      #1;
      ok_done = (owner != 0) && bus_ack;
      abort   = (owner != 0) && !bus_ack && (age == TIMEOUT - 1);
      check_val("bus_req", bus_req, owner != 0);
      if (owner != 0) begin
        check_val("bus_addr", bus_addr, t_addr);
        check_val("bus_we", bus_we, t_we);
        check_val("bus_wstrb", bus_wstrb, t_wstrb);
        if (owner == 2) check_val("bus_wdata", bus_wdata, t_wdata);
      end
      check_val("bus_err", bus_err, abort);
      check_val("if_ack", if_ack, (owner == 1) && (ok_done || abort) && !dropped);
      check_val("if_rdata", if_rdata, (owner == 1 && bus_ack) ? bus_rdata : 32'h0);
      check_val("mem_ack", mem_ack, (owner == 2) && (ok_done || abort));
      check_val("mem_rdata", mem_rdata, (owner == 2 && bus_ack) ? bus_rdata : 32'h0);

      if (owner != 0) begin
        if (ok_done || abort) begin
          ntxn++;
          $display("txn %0d owner=%s addr=%h we=%0b age=%0d %s%s", ntxn, (owner == 1) ? "IF" : "MEM",
                   t_addr, t_we, age, abort ? "timeout" : "acked", dropped ? " dropped" : "");
          owner = 0; dropped = 0;
        end else begin
          age++;
          if (owner == 1 && flush) dropped = 1;
        end
      end else begin
        // IF wins when eligible and either MEM is quiet or MEM already had STARVE_LIMIT grants in a row.
        elig = if_req && !flush;
        if (elig && (streak == STARVE_LIMIT || !mem_req)) begin
          owner = 1; age = 0; streak = 0;
          t_addr = if_addr; t_we = 1'b0; t_wdata = '0; t_wstrb = '0;
        end else if (mem_req) begin
          owner = 2; age = 0;
          t_addr = mem_addr; t_we = mem_we; t_wdata = mem_wdata; t_wstrb = mem_wstrb;
          streak = !if_req ? 0 : (streak < STARVE_LIMIT ? streak + 1 : streak);
        end else if (!if_req) begin
          streak = 0;
        end
      end

      seen_if_ack  = if_ack;
      seen_mem_ack = mem_ack;
      last_flush   = flush;
      if (sl_active) begin
        if (bus_ack || bus_err) sl_active = 0;
        else sl_cnt++;
      end

      if (cyc == NCYC / 2) begin
        #1 rst = 1'b1;
        #1;
        check_val("async_rst_bus_req", bus_req, 0);
        check_val("async_rst_mem_ack", mem_ack, 0);
        check_val("async_rst_if_ack", if_ack, 0);
        if_req = 1'b0; mem_req = 1'b0; bus_ack = 1'b0; flush = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end else begin
        @(negedge clk);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
